hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline sequencer for the 5-stage (IF, ID, EX, MEM, WB) SPARC-subset core. It sits beside the ID-stage control decoder and consumes the decoder's register fields and control flags.
- Tracks in-flight destination registers through EX/MEM/WB. Drives the PC, nPC and IF/ID enables, the ID control-bubble mux and the delay-slot annul, and produces ID-stage operand forwarding selects.
- Owns the load-use stall and memory-wait freeze state machine.

Parameters:
- MAX_WAIT, 16, maximum consecutive mem_wait cycles before wait_err asserts.
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_rs1, id_rs2, id_rd  in  5 each  ID register fields (rd already forced to 15 for call).
- id_rf_le  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- id_use_rs2  in  1  ID reads rs2 (register operand, not immediate).
- br_taken  in  1  branch/call/jmpl in ID resolved taken this cycle.
- br_annul  in  1  annul bit (instr[29]) of the branch in ID.
- mem_wait  in  1  data RAM not ready; MEM stage must hold.
- pc_le, npc_le, ifid_le  out  1 each  pipeline register enables.
- id_bubble  out  1  force ID control outputs to NOP into EX.
- ifid_clr  out  1  squash the instruction entering IF/ID (annul).
- exmem_le, memwb_le  out  1 each  back-end register enables.
- fwd_a, fwd_b  out  2 each  operand select: 00 RF, 01 EX, 10 MEM, 11 WB.
- wait_err  out  1  sticky: mem_wait exceeded MAX_WAIT.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - FSM goes to RUN; all shadow-stage valid bits are cleared.
  - Enables (pc_le, npc_le, ifid_le, exmem_le, memwb_le) = 1.
  - id_bubble = 0, ifid_clr = 0, fwd_a = fwd_b = 00, wait_err = 0, wait counter = 0.
- Shadow pipe:
  - Each stage register (EX, MEM, WB) holds {valid, rd, rf_le, load}.
  - On each enabled edge, ID→EX captures the ID fields, with valid = id_valid & ~id_bubble; EX→MEM and MEM→WB shift.
  - When EX→MEM is frozen, all three stages hold.
- Forwarding is combinational from current shadow state:
  - A hit requires stage valid, rf_le, rd == rs, and rs != 0 (r0/g0 never forwarded).
  - Priority EX > MEM > WB. fwd_b is forced to 00 when id_use_rs2 = 0.
- Load-use hazard: EX holds a valid load whose rd hits rs1 (or rs2 when used).
- FSM states and transitions:
  - RUN: on mem_wait → WAIT. Otherwise on a load-use hazard → LU.
    - The hazard cycle itself drives pc_le = npc_le = ifid_le = 0 and id_bubble = 1; exactly one bubble is inserted.
  - LU: all enables = 1, no bubble; the load is now in MEM, so the forward select resolves to 10. Return to RUN; a mem_wait seen here → WAIT.
  - WAIT: all enables = 0, id_bubble = 0, wait counter increments.
    - When mem_wait drops → RUN and the counter clears.
    - When counter == MAX_WAIT−1 with mem_wait still high, wait_err sets (sticky until rst) and the state stays WAIT.
- Simultaneous events:
  - mem_wait dominates a load-use hazard: freeze first, then re-evaluate on exit.
  - br_taken during a stall is ignored; the branch is re-presented when ID advances.
- Annul:
  - ifid_clr = 1 for one cycle when br_annul = 1, ifid_le = 1, and br_annul_effective holds.
  - br_annul_effective = (branch not taken) or (taken unconditional branch-always, signalled as br_taken & br_annul).
  - Net rule: annul whenever br_annul = 1 and ID is advancing. A taken conditional branch with the annul bit clear executes its delay slot.
- Reset mid-stall: immediate return to RUN with the reset values above; any in-flight wait is abandoned.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [CNT_W-1:0], incremented every cycle where pc_le = 0.
  - Saturates at all-ones and clears on rst.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (core_pkg):
  - FSM state enum {RUN, LU, WAIT}.
  - Forward-select constants FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
  - Shadow-stage struct {valid, rd, rf_le, load}.
  - REG_G0 = 5'd0 and CALL_RD = 5'd15.
- Sub-module fwd_sel: purely combinational priority compare for one operand, instantiated twice (fwd_a, fwd_b).

Test Plan:
- Back-to-back ALU ops:
  - Stimulus: add r3 (rd = 3), then an instruction with rs1 = 3.
  - Required: fwd_a = 01. Next cycle, an rs2 = 3 read gives fwd_b = 10. No stall.
- Load-use:
  - Stimulus: load rd = 5 followed by rs1 = 5.
  - Required: exactly one cycle of pc_le = 0 and id_bubble = 1, then fwd_a = 10 with all enables = 1.
- g0 write:
  - Stimulus: load with rd = 0, then an instruction with rs1 = 0.
  - Required: no stall, fwd_a = 00.
- Memory wait:
  - Stimulus: mem_wait high for 3 cycles coincident with a load-use hazard.
  - Required: all enables = 0 for 3 cycles, then the single load-use bubble.
  - Stimulus: mem_wait high for 16 cycles.
  - Required: wait_err = 1, and it remains 1 after mem_wait drops.
- Annul:
  - Stimulus: br_annul = 1, br_taken = 0 → ifid_clr = 1 for one cycle.
  - Stimulus: br_annul = 0, br_taken = 1 → ifid_clr = 0.
- Reset and counter:
  - Stimulus: rst asserted mid-WAIT.
  - Required: outputs return to reset values asynchronously.
  - With HAZARD_STALL_CNT_EN defined: stall_cnt counts 1 for a load-use and 3 for a 3-cycle wait.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the SPARC-subset pipeline sequencer:
// FSM states, forwarding selects, shadow-stage record and register helpers.
package core_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LU   = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_G0  = 5'd0;
  localparam logic [4:0] CALL_RD = 5'd15;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_le;
    logic       load;
  } stage_t;

  // A stage can supply an operand only if it will really write that register; g0 is hardwired.
  function automatic logic stage_hit(input stage_t s, input logic [4:0] rs);
    return s.valid && s.rf_le && (s.rd == rs) && (rs != REG_G0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Priority forwarding select for one ID-stage source operand.
// The youngest in-flight producer wins: EX over MEM over WB.
module fwd_sel
  import core_pkg::*;
(
  input  stage_t     ex_stage,
  input  stage_t     mem_stage,
  input  stage_t     wb_stage,
  input  logic [4:0] rs,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (stage_hit(ex_stage, rs)) begin
      sel = FWD_EX;
    end else if (stage_hit(mem_stage, rs)) begin
      sel = FWD_MEM;
    end else if (stage_hit(wb_stage, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer: shadow rd tracking, forwarding, load-use stall and memory-wait freeze.
// Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl_unit
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 16
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_le,
  input  logic             id_load,
  input  logic             id_use_rs2,
  input  logic             br_taken,
  input  logic             br_annul,
  input  logic             mem_wait,
  output logic             pc_le,
  output logic             npc_le,
  output logic             ifid_le,
  output logic             id_bubble,
  output logic             ifid_clr,
  output logic             exmem_le,
  output logic             memwb_le,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             wait_err
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  stage_t            ex_q, mem_q, wb_q;
  stage_t            ex_d;
  logic [WCNT_W-1:0] wait_cnt;
  logic [1:0]        sel_a, sel_b;
  logic              lu_hazard;
  logic              annul_effective;

  fwd_sel u_fwd_a (
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .rs        (id_rs1),
    .sel       (sel_a)
  );

  fwd_sel u_fwd_b (
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .rs        (id_rs2),
    .sel       (sel_b)
  );

  assign fwd_a = sel_a;
  assign fwd_b = id_use_rs2 ? sel_b : FWD_RF;

  // A load in EX cannot forward its data until it reaches MEM, so ID must wait one cycle.
  assign lu_hazard = ex_q.load &&
                     (stage_hit(ex_q, id_rs1) || (id_use_rs2 && stage_hit(ex_q, id_rs2)));

  always_comb begin
    state_d   = state_q;
    pc_le     = 1'b1;
    ifid_le   = 1'b1;
    id_bubble = 1'b0;
    exmem_le  = 1'b1;
    if (!rst) begin
      unique case (state_q)
        RUN, WAIT: begin
          if (mem_wait) begin
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            exmem_le = 1'b0;
            state_d  = WAIT;
          end else if (lu_hazard) begin
            pc_le     = 1'b0;
            ifid_le   = 1'b0;
            id_bubble = 1'b1;
            state_d   = LU;
          end else begin
            state_d = RUN;
          end
        end
        LU: begin
          if (mem_wait) begin
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            exmem_le = 1'b0;
            state_d  = WAIT;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign npc_le   = pc_le;
  assign memwb_le = exmem_le;

  // Annul only when ID advances; a stalled branch is re-presented and decides then.
  assign annul_effective = !br_taken || (br_taken && br_annul);
  assign ifid_clr        = br_annul && ifid_le && annul_effective;

  assign ex_d = '{valid: id_valid && !id_bubble, rd: id_rd, rf_le: id_rf_le, load: id_load};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (exmem_le) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

  // Counts consecutive mem_wait cycles; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      wait_err <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt == WCNT_LAST) begin
        wait_err <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_le && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit with an expected-output queue.
// Stall counter checks are compiled in when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_ctrl_unit;
  import core_pkg::*;

  typedef struct packed {
    logic       pc;
    logic       npc;
    logic       ifid;
    logic       bub;
    logic       clr;
    logic       exm;
    logic       mwb;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rf_le, id_load, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       br_taken, br_annul, mem_wait;
  logic       pc_le, npc_le, ifid_le, id_bubble, ifid_clr, exmem_le, memwb_le, wait_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  exp_t exp_q[$];
  int   total_checks = 0;
  int   pass_checks  = 0;

  hazard_ctrl_unit dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_rf_le   (id_rf_le),
    .id_load    (id_load),
    .id_use_rs2 (id_use_rs2),
    .br_taken   (br_taken),
    .br_annul   (br_annul),
    .mem_wait   (mem_wait),
    .pc_le      (pc_le),
    .npc_le     (npc_le),
    .ifid_le    (ifid_le),
    .id_bubble  (id_bubble),
    .ifid_clr   (ifid_clr),
    .exmem_le   (exmem_le),
    .memwb_le   (memwb_le),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .wait_err   (wait_err)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic pushExpected(input logic e_pc, e_bub, e_clr, e_ex,
                              input logic [1:0] e_fa, e_fb, input logic e_err);
    exp_q.push_back({e_pc, e_pc, e_pc, e_bub, e_clr, e_ex, e_ex, e_fa, e_fb, e_err});
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    exp_t obs;
    obs = {pc_le, npc_le, ifid_le, id_bubble, ifid_clr, exmem_le, memwb_le, fwd_a, fwd_b, wait_err};
    total_checks++;
    if (exp_q.size() == 0) begin
      $error("[TB] FAIL %s scoreboard empty, observed %b", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) pass_checks++;
      else $error("[TB] FAIL %s observed %b expected %b (pc npc ifid bub clr exm mwb fa fb err)",
                  tag, obs, e);
    end
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic checkCount(input string tag, input logic [15:0] e_cnt);
    total_checks++;
    assert (stall_cnt === e_cnt) pass_checks++;
    else $error("[TB] FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt, e_cnt);
  endtask
`endif

  // Drive one ID-stage cycle after the falling edge and compare mid-low-phase.
  task automatic applyStimulus(input string tag,
                               input logic v, input logic [4:0] rs1, rs2, rd,
                               input logic rfle, ld, use2, bt, ba, mw,
                               input logic e_pc, e_bub, e_clr, e_ex,
                               input logic [1:0] e_fa, e_fb, input logic e_err);
    @(negedge clk);
    id_valid   = v;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rd      = rd;
    id_rf_le   = rfle;
    id_load    = ld;
    id_use_rs2 = use2;
    br_taken   = bt;
    br_annul   = ba;
    mem_wait   = mw;
    pushExpected(e_pc, e_bub, e_clr, e_ex, e_fa, e_fb, e_err);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rf_le = 0; id_load = 0;
    id_use_rs2 = 0; br_taken = 0; br_annul = 0; mem_wait = 0;
    #2;
    pushExpected(1, 0, 0, 1, FWD_RF, FWD_RF, 0);
    checkOutput("reset_values");
`ifdef HAZARD_STALL_CNT_EN
    checkCount("reset_cnt", 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    //            tag                  v rs1    rs2    rd     rf ld u2 bt ba mw  pc bub clr ex fa       fb       err
    applyStimulus("alu_add_r3",        1, 5'd1,  5'd2,  5'd3,  1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("fwd_a_ex",          1, 5'd3,  5'd4,  5'd6,  1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_EX,  FWD_RF,  0);
    applyStimulus("fwd_b_mem",         1, 5'd7,  5'd3,  5'd8,  1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_MEM, 0);
    applyStimulus("fwd_a_wb_rs2_off",  1, 5'd3,  5'd6,  5'd9,  1, 0, 0, 0, 0, 0, 1, 0, 0, 1, FWD_WB,  FWD_RF,  0);
    applyStimulus("prio_ex_mem",       1, 5'd9,  5'd8,  5'd9,  1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_EX,  FWD_MEM, 0);
    applyStimulus("prio_ex_both",      1, 5'd9,  5'd9,  5'd10, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_EX,  FWD_EX,  0);
    applyStimulus("no_fwd_rf_le_off",  1, 5'd10, 5'd9,  5'd0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_MEM, 0);
    applyStimulus("load_r5",           1, 5'd1,  5'd0,  5'd5,  1, 1, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("lu_stall",          1, 5'd5,  5'd2,  5'd11, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, FWD_EX,  FWD_RF,  0);
    applyStimulus("lu_resolve",        1, 5'd5,  5'd2,  5'd11, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_MEM, FWD_RF,  0);
`ifdef HAZARD_STALL_CNT_EN
    checkCount("cnt_after_lu", 16'd1);
`endif
    applyStimulus("after_lu",          1, 5'd5,  5'd11, 5'd12, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_WB,  FWD_EX,  0);
    applyStimulus("load_g0",           1, 5'd2,  5'd0,  5'd0,  1, 1, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("g0_no_stall",       1, 5'd0,  5'd0,  5'd13, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("load_r7",           1, 5'd1,  5'd0,  5'd7,  1, 1, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("mw_freeze_%0d", i),
                                       1, 5'd2,  5'd7,  5'd14, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, FWD_RF,  FWD_EX,  0);
    end
    applyStimulus("mw_exit_lu",        1, 5'd2,  5'd7,  5'd14, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, FWD_RF,  FWD_EX,  0);
`ifdef HAZARD_STALL_CNT_EN
    checkCount("cnt_after_wait", 16'd4);
`endif
    applyStimulus("mw_lu_fwd",         1, 5'd2,  5'd7,  5'd14, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_MEM, 0);
`ifdef HAZARD_STALL_CNT_EN
    checkCount("cnt_after_wait_lu", 16'd5);
`endif
    applyStimulus("annul_not_taken",   1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 1, 0, 1, 0, 1, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("taken_no_annul",    1, 5'd14, 5'd0,  5'd0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 1, FWD_MEM, FWD_RF,  0);
    applyStimulus("annul_ba",          1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1, 1, 0, 1, 0, 1, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("clr_one_cycle",     1, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("load_r20",          1, 5'd0,  5'd0,  5'd20, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    applyStimulus("annul_in_stall",    1, 5'd20, 5'd0,  5'd0,  0, 0, 0, 1, 1, 0, 0, 1, 0, 1, FWD_EX,  FWD_RF,  0);
    applyStimulus("annul_after_stall", 1, 5'd20, 5'd0,  5'd0,  0, 0, 0, 1, 1, 0, 1, 0, 1, 1, FWD_MEM, FWD_RF,  0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus($sformatf("mw15_%0d", i), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    end
    applyStimulus("mw15_exit_no_err",  0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("mw16_%0d", i), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    end
    applyStimulus("mw16_err_set",      0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  1);
    applyStimulus("err_sticky",        0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, FWD_RF,  FWD_RF,  1);

    applyStimulus("rw_wait_0",         0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  1);
    applyStimulus("rw_wait_1",         0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  1);
    #2;
    rst = 1'b1;
    pushExpected(1, 0, 0, 1, FWD_RF, FWD_RF, 0);
    #1;
    checkOutput("rst_async_mid_wait");
`ifdef HAZARD_STALL_CNT_EN
    checkCount("cnt_cleared", 16'd0);
`endif
    @(negedge clk);
    rst      = 1'b0;
    mem_wait = 1'b0;
    pushExpected(1, 0, 0, 1, FWD_RF, FWD_RF, 0);
    #1;
    checkOutput("post_rst_run");

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
